// File: rtl/mdu_param.sv
// Multiply/divide unit holding HI/LO, with optional multiply-accumulate ops.
// Latency: MULT_CYCLES or DIV_CYCLES busy cycles; the result is visible on the first cycle busy is low.
// Backpressure: ops issued while busy are dropped; the hazard unit stalls on busy.
module mdu_param #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int ENABLE_MAC  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [3:0]       mdu_op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic [WIDTH-1:0] mdu_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    localparam logic [4:0] MULT_LAT = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_LAT  = 5'(DIV_CYCLES);
    localparam int         W2       = 2 * WIDTH;

    logic [0:0]       state;
    logic [4:0]       counter;
    logic             busy_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [W2-1:0]    pend_dat;
    logic             pend_vld;

    logic is_mul;
    logic is_mac;
    logic is_div;
    logic start;

    always_comb begin
        is_mul = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
        is_mac = (ENABLE_MAC != 0) &&
                 ((mdu_op == OP_MADD) || (mdu_op == OP_MADDU) ||
                  (mdu_op == OP_MSUB) || (mdu_op == OP_MSUBU));
        is_div = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
        start  = (state == S_IDLE) && !req && (is_mul || is_mac || is_div);
    end

    // Products are formed at 2*WIDTH so the low half of the wrapped product is exact for both signednesses.
    logic [W2-1:0] rs_sx;
    logic [W2-1:0] rt_sx;
    logic [W2-1:0] rs_zx;
    logic [W2-1:0] rt_zx;
    logic [W2-1:0] prod_s;
    logic [W2-1:0] prod_u;
    logic [W2-1:0] acc;

    assign rs_sx  = {{WIDTH{rs[WIDTH-1]}}, rs};
    assign rt_sx  = {{WIDTH{rt[WIDTH-1]}}, rt};
    assign rs_zx  = {{WIDTH{1'b0}}, rs};
    assign rt_zx  = {{WIDTH{1'b0}}, rt};
    assign prod_s = rs_sx * rt_sx;
    assign prod_u = rs_zx * rt_zx;
    assign acc    = {hi_q, lo_q};

    // Signed divide runs on magnitudes; the most-negative magnitude still fits unsigned.
    logic             signed_div;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;
    logic [WIDTH-1:0] div_num;
    logic [WIDTH-1:0] div_den;
    logic [WIDTH-1:0] quo_u;
    logic [WIDTH-1:0] rem_u;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    always_comb begin
        signed_div = (mdu_op == OP_DIV);
        rs_neg     = signed_div && rs[WIDTH-1];
        rt_neg     = signed_div && rt[WIDTH-1];
        rs_mag     = rs_neg ? -rs : rs;
        rt_mag     = rt_neg ? -rt : rt;
        div_num    = rs_mag;
        div_den    = (rt_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : rt_mag;
        quo_u      = div_num / div_den;
        rem_u      = div_num % div_den;
        quo        = (rs_neg ^ rt_neg) ? -quo_u : quo_u;
        rem        = rs_neg ? -rem_u : rem_u;
    end

    logic [W2-1:0] res_dat;
    logic          res_vld;

    always_comb begin
        res_dat = prod_s;
        res_vld = 1'b1;
        case (mdu_op)
            OP_MULT:  res_dat = prod_s;
            OP_MULTU: res_dat = prod_u;
            OP_MADD:  res_dat = acc + prod_s;
            OP_MADDU: res_dat = acc + prod_u;
            OP_MSUB:  res_dat = acc - prod_s;
            OP_MSUBU: res_dat = acc - prod_u;
            OP_DIV, OP_DIVU: begin
                res_dat = {rem, quo};
                res_vld = (rt != '0);
            end
            default: res_dat = prod_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            counter  <= 5'd0;
            busy_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            pend_dat <= '0;
            pend_vld <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pend_dat <= res_dat;
                        pend_vld <= res_vld;
                        counter  <= is_div ? DIV_LAT : MULT_LAT;
                        busy_q   <= 1'b1;
                        state    <= S_RUN;
                    end else if (!req && mdu_op == OP_MTHI) begin
                        hi_q <= rs;
                    end else if (!req && mdu_op == OP_MTLO) begin
                        lo_q <= rs;
                    end
                end
                S_RUN: begin
                    counter <= counter - 5'd1;
                    if (counter == 5'd1) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        if (pend_vld) begin
                            hi_q <= pend_dat[W2-1:WIDTH];
                            lo_q <= pend_dat[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign mdu_out = (mdu_op == OP_MFHI) ? hi_q :
                     (mdu_op == OP_MFLO) ? lo_q : '0;

endmodule
